// File: rtl/lpm_pkg.sv
// Shared constants for the LPM table responder and its response queue.
// No logic of its own; the saturating increment is shared by the error counter.
// Backpressure: not applicable.
package lpm_pkg;

    localparam int          DEPTH_LOG2_DFLT = 8;
    localparam int          ERRCNT_W        = 16;
    localparam logic [31:0] MISS_VALUE      = 32'h0000_0001;  // leaf with no route

    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        return (&v) ? v : v + ERRCNT_W'(1);
    endfunction

endpackage

// File: rtl/lpm_table_responder_resq.sv
// Response queue: enq/first/deq FIFO with wrap-around pointers plus occupancy count.
// Latency: an entry enqueued at an edge is presented on first_o right after that edge.
// Backpressure: none internally; the owner's credit scheme never enqueues into a full queue.
module LpmResQueue #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             enq_ena_i,
    input  logic [WIDTH-1:0] enq_dat_i,
    input  logic             deq_ena_i,
    output logic [WIDTH-1:0] first_o,
    output logic             not_empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deq;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign not_empty_o = (cnt_q != '0);
    assign deq         = deq_ena_i & not_empty_o;
    assign first_o     = not_empty_o ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        wr_ptr_d = enq_ena_i ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(enq_ena_i) - CNT_W'(deq);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (enq_ena_i) begin
            mem_q[wr_ptr_q] <= enq_dat_i;
        end
    end

endmodule

// File: rtl/lpm_table_responder.sv
// LPM table lookup: word-addressed table read, out-of-range requests answered with MISS_VALUE.
// Latency: response enters the queue LATENCY cycles after acceptance, in request order.
// Backpressure: credit-based; req__RDY drops when in-flight plus queued reaches RESQ_DEPTH.
module lpm_table_responder
    import lpm_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEPTH_LOG2_DFLT,
    parameter int LATENCY    = 2,
    parameter int RESQ_DEPTH = 4
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  req__ENA,
    input  logic [31:0]           req_v,
    output logic                  req__RDY,
    output logic [31:0]           resValue,
    output logic                  resValue__RDY,
    input  logic                  resAccept__ENA,
    output logic                  resAccept__RDY,
    input  logic                  write__ENA,
    input  logic [DEPTH_LOG2-1:0] write_addr,
    input  logic [31:0]           write_data,
    output logic                  write__RDY,
    output logic [ERRCNT_W-1:0]   errCount
);

    localparam int CRD_W = $clog2(RESQ_DEPTH + 1);

    logic [31:0]         tbl_q [2**DEPTH_LOG2];
    logic [31:0]         pd_q  [LATENCY];
    logic [LATENCY-1:0]  pv_q, pv_d;
    logic [CRD_W-1:0]    crd_q, crd_d;
    logic [ERRCNT_W-1:0] err_q, err_d;
    logic                req_acc, deq, oor, q_not_empty;
    logic [31:0]         lkp_dat;

    assign oor     = |req_v[31:DEPTH_LOG2];
    assign lkp_dat = oor ? MISS_VALUE : tbl_q[req_v[DEPTH_LOG2-1:0]];

    // A pop in the same cycle frees a credit, so a full queue still takes one request per pop.
    assign deq      = resAccept__ENA & q_not_empty;
    assign req__RDY = (crd_q != CRD_W'(RESQ_DEPTH)) | deq;
    assign req_acc  = req__ENA & req__RDY;

    assign resValue__RDY  = q_not_empty;
    assign resAccept__RDY = q_not_empty;
    assign write__RDY     = 1'b1;
    assign errCount       = err_q;

    always_comb begin
        pv_d    = pv_q << 1;
        pv_d[0] = req_acc;
        crd_d   = crd_q + CRD_W'(req_acc) - CRD_W'(deq);
        err_d   = (req_acc && oor) ? sat_inc(err_q) : err_q;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pv_q  <= '0;
            crd_q <= '0;
            err_q <= '0;
        end else begin
            pv_q  <= pv_d;
            crd_q <= crd_d;
            err_q <= err_d;
        end
    end

    // Table read samples the pre-write contents, so a same-cycle write is seen only by later reads.
    always_ff @(posedge CLK) begin
        pd_q[0] <= lkp_dat;
        for (int i = 1; i < LATENCY; i++) begin
            pd_q[i] <= pd_q[i-1];
        end
        if (write__ENA) begin
            tbl_q[write_addr] <= write_data;
        end
    end

    LpmResQueue #(
        .DEPTH (RESQ_DEPTH),
        .WIDTH (32)
    ) u_resq (
        .CLK         (CLK),
        .nRST        (nRST),
        .enq_ena_i   (pv_q[LATENCY-1]),
        .enq_dat_i   (pd_q[LATENCY-1]),
        .deq_ena_i   (resAccept__ENA),
        .first_o     (resValue),
        .not_empty_o (q_not_empty)
    );

endmodule

// File: tb/tb_lpm_table_responder.sv
// Directed bench for lpm_table_responder: vector table for single lookups plus
// sequences for backpressure, read-before-write, full-queue streaming, reset and saturation.
module tb_lpm_table_responder;

    localparam int LAT = 2;
    localparam int QD  = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        req__ENA;
    logic [31:0] req_v;
    logic        req__RDY;
    logic [31:0] resValue;
    logic        resValue__RDY;
    logic        resAccept__ENA;
    logic        resAccept__RDY;
    logic        write__ENA;
    logic [7:0]  write_addr;
    logic [31:0] write_data;
    logic        write__RDY;
    logic [15:0] errCount;

    always #5 CLK = ~CLK;

    lpm_table_responder #(
        .DEPTH_LOG2 (8),
        .LATENCY    (LAT),
        .RESQ_DEPTH (QD)
    ) dut (
        .CLK            (CLK),
        .nRST           (nRST),
        .req__ENA       (req__ENA),
        .req_v          (req_v),
        .req__RDY       (req__RDY),
        .resValue       (resValue),
        .resValue__RDY  (resValue__RDY),
        .resAccept__ENA (resAccept__ENA),
        .resAccept__RDY (resAccept__RDY),
        .write__ENA     (write__ENA),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .write__RDY     (write__RDY),
        .errCount       (errCount)
    );

    int pass_cnt = 0;
    int total_cnt = 0;
    int acc_cnt = 0;
    logic [31:0] tbl_m [256];
    logic [31:0] exp_q [$];

    typedef struct {
        string       nm;
        logic [31:0] addr;
        logic [31:0] exp_val;
        logic [15:0] exp_err;
    } vec_t;
    vec_t vecs [7];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, required %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        write__ENA = 1'b1;
        write_addr = 8'(a);
        write_data = d;
        step();
        write__ENA = 1'b0;
    endtask

    task automatic pop_expect(input string nm, input logic [31:0] exp);
        int n = 0;
        while (!resValue__RDY && n < 10) begin
            step();
            n++;
        end
        check({nm, "_rdy"}, 32'(resValue__RDY), 32'd1);
        check(nm, resValue, exp);
        resAccept__ENA = 1'b1;
        step();
        resAccept__ENA = 1'b0;
    endtask

    // Reference model: accepted requests queue their expected word; every DUT pop is compared.
    always @(negedge CLK) begin
        if (nRST) begin
            if (req__ENA && req__RDY) begin
                acc_cnt++;
                if (req_v[31:8] != 24'd0) exp_q.push_back(32'h0000_0001);
                else exp_q.push_back(tbl_m[req_v[7:0]]);
            end
            if (write__ENA) tbl_m[write_addr] = write_data;
            if (resAccept__ENA && resValue__RDY) begin
                if (exp_q.size() == 0) begin
                    total_cnt++;
                    $display("FAIL mon_extra_pop: got %h, required no response", resValue);
                end else begin
                    check("mon_order", resValue, exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: time limit reached, pass %0d of %0d", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, k, n, base;
        logic [31:0] b2b_addr [6];

        nRST = 1'b1; req__ENA = 1'b0; req_v = '0; resAccept__ENA = 1'b0;
        write__ENA = 1'b0; write_addr = '0; write_data = '0;
        #2 nRST = 1'b0;
        repeat (3) step();
        check("rst_req_rdy",    32'(req__RDY),       32'd1);
        check("rst_res_rdy",    32'(resValue__RDY),  32'd0);
        check("rst_acc_rdy",    32'(resAccept__RDY), 32'd0);
        check("rst_res_value",  resValue,            32'd0);
        check("rst_err",        32'(errCount),       32'd0);
        check("rst_write_rdy",  32'(write__RDY),     32'd1);
        nRST = 1'b1;
        step();

        wr(5, 32'h0000_0A10);
        wr(0, 32'hDEAD_BEEF);
        wr(255, 32'h1234_5678);
        wr(7, 32'hBBBB_0007);
        for (int i = 16; i < 64; i++) wr(i, 32'hC000_0000 | 32'(i));

        vecs[0] = '{"v_addr5",   32'h0000_0005, 32'h0000_0A10, 16'd0};
        vecs[1] = '{"v_addr0",   32'h0000_0000, 32'hDEAD_BEEF, 16'd0};
        vecs[2] = '{"v_addr255", 32'h0000_00FF, 32'h1234_5678, 16'd0};
        vecs[3] = '{"v_oor_hi",  32'h0001_0003, 32'h0000_0001, 16'd1};
        vecs[4] = '{"v_oor_256", 32'h0000_0100, 32'h0000_0001, 16'd2};
        vecs[5] = '{"v_oor_msb", 32'h8000_0005, 32'h0000_0001, 16'd3};
        vecs[6] = '{"v_addr7",   32'h0000_0007, 32'hBBBB_0007, 16'd3};
        for (int i = 0; i < 7; i++) begin
            req_v = vecs[i].addr;
            req__ENA = 1'b1;
            step();
            req__ENA = 1'b0;
            repeat (LAT - 1) step();
            check({vecs[i].nm, "_early"}, 32'(resValue__RDY), 32'd0);
            step();
            check({vecs[i].nm, "_rdy"}, 32'(resValue__RDY), 32'd1);
            check({vecs[i].nm, "_acc_rdy"}, 32'(resAccept__RDY), 32'd1);
            check(vecs[i].nm, resValue, vecs[i].exp_val);
            check({vecs[i].nm, "_err"}, 32'(errCount), 32'(vecs[i].exp_err));
            resAccept__ENA = 1'b1;
            step();
            resAccept__ENA = 1'b0;
            check({vecs[i].nm, "_empty_val"}, resValue, 32'd0);
        end

        // Six back-to-back requests without pops: only the queue depth is accepted.
        b2b_addr = '{32'd0, 32'd5, 32'd255, 32'd7, 32'd0, 32'd5};
        acc = 0;
        req__ENA = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_v = b2b_addr[i];
            #1;
            if (req__RDY) acc++;
            step();
        end
        req__ENA = 1'b0;
        check("b2b_accepted", 32'(acc), 32'd4);
        check("b2b_rdy_low", 32'(req__RDY), 32'd0);
        check("b2b_head", resValue, 32'hDEAD_BEEF);
        resAccept__ENA = 1'b1;
        step();
        resAccept__ENA = 1'b0;
        check("b2b_rdy_back", 32'(req__RDY), 32'd1);
        pop_expect("b2b_pop2", 32'h0000_0A10);
        pop_expect("b2b_pop3", 32'h1234_5678);
        pop_expect("b2b_pop4", 32'hBBBB_0007);

        // Same-cycle write and read of one address: the read sees the old word.
        write__ENA = 1'b1; write_addr = 8'd7; write_data = 32'hAAAA_0007;
        req__ENA = 1'b1; req_v = 32'd7;
        step();
        write__ENA = 1'b0;
        step();
        req__ENA = 1'b0;
        pop_expect("rbw_old", 32'hBBBB_0007);
        pop_expect("rbw_new", 32'hAAAA_0007);

        // Fill the queue, then stream with a request and a pop every cycle.
        k = 16;
        req__ENA = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_v = 32'(k);
            #1;
            if (req__RDY) k++;
            step();
        end
        check("full_rdy_low", 32'(req__RDY), 32'd0);
        check("full_credits", 32'(exp_q.size()), 32'd4);
        resAccept__ENA = 1'b1;
        for (int i = 0; i < 20; i++) begin
            req_v = 32'(k);
            #1;
            check("stream_credits", 32'(exp_q.size()), 32'd4);
            check("stream_res_rdy", 32'(resValue__RDY), 32'd1);
            if (req__RDY) k++;
            step();
        end
        req__ENA = 1'b0;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            step();
            n++;
        end
        resAccept__ENA = 1'b0;
        step();
        check("stream_accepted", 32'(k - 16), 32'd24);
        check("stream_no_loss", 32'(exp_q.size()), 32'd0);
        check("stream_empty", 32'(resValue__RDY), 32'd0);
        check("stream_empty_val", resValue, 32'd0);

        // Reset with lookups still in flight.
        req__ENA = 1'b1; req_v = 32'd5;
        repeat (3) step();
        req__ENA = 1'b0;
        nRST = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_req_rdy", 32'(req__RDY),       32'd1);
        check("mid_rst_res_rdy", 32'(resValue__RDY),  32'd0);
        check("mid_rst_acc_rdy", 32'(resAccept__RDY), 32'd0);
        check("mid_rst_value",   resValue,            32'd0);
        check("mid_rst_err",     32'(errCount),       32'd0);
        repeat (2) step();
        nRST = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check("post_rst_quiet", 32'(resValue__RDY), 32'd0);
        end

        // Error counter saturation over 70000 out-of-range lookups.
        base = acc_cnt;
        n = 0;
        req_v = 32'h0001_0003;
        req__ENA = 1'b1;
        resAccept__ENA = 1'b1;
        while ((acc_cnt - base) < 70000 && n < 80000) begin
            step();
            n++;
        end
        req__ENA = 1'b0;
        check("sat_accepted", 32'(acc_cnt - base), 32'd70000);
        check("sat_err", 32'(errCount), 32'h0000_FFFF);
        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            step();
            n++;
        end
        resAccept__ENA = 1'b0;
        step();
        check("sat_drained", 32'(exp_q.size()), 32'd0);
        check("sat_err_hold", 32'(errCount), 32'h0000_FFFF);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/lpm_table_responder.md
LPM_TABLE_RESPONDER -- requirements
Module: lpm_table_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 8, giving log2 of the table depth in 32-bit words.
REQ-002 SHALL have parameter LATENCY, default 2, giving the table read pipeline depth in cycles (legal range 1..4).
REQ-003 SHALL have parameter RESQ_DEPTH, default 4, giving the response queue depth in entries (power of two, at least LATENCY).
REQ-004 SHALL have a single clock and an asynchronous, active-low reset: CLK and nRST.
REQ-005 SHALL have ports CLK, input, 1, clock.
REQ-006 SHALL have ports nRST, input, 1, asynchronous active-low reset.
REQ-007 SHALL have ports req__ENA, input, 1, lookup request strobe.
REQ-008 SHALL have ports req$v, input, 32, table word address.
REQ-009 SHALL have ports req__RDY, output, 1, lookup request can be accepted.
REQ-010 SHALL have ports resValue, output, 32, head-of-queue response word.
REQ-011 SHALL have ports resValue__RDY, output, 1, response queue non-empty.
REQ-012 SHALL have ports resAccept__ENA, input, 1, pop head response.
REQ-013 SHALL have ports resAccept__RDY, output, 1, equal to resValue__RDY.
REQ-014 SHALL have ports write__ENA, input, 1, table load strobe.
REQ-015 SHALL have ports write$addr, input, DEPTH_LOG2, table load address.
REQ-016 SHALL have ports write$data, input, 32, table load data.
REQ-017 SHALL have ports write__RDY, output, 1, constant 1.
REQ-018 SHALL have ports errCount, output, 16, saturating out-of-range request count.

Function
REQ-019 SHALL accept a request on a cycle where req__ENA and req__RDY are both high; req__ENA with req__RDY low is a protocol violation and is ignored.
REQ-020 SHALL deassert req__RDY when credits (pipeline occupancy plus queue count) reach RESQ_DEPTH, so the queue never overflows.
REQ-021 SHALL apply a credit change of +1 for an accepted request and -1 for an accepted resAccept; both in one cycle leave credits unchanged.
REQ-022 SHALL write the response into the queue exactly LATENCY cycles after acceptance, so resValue__RDY rises at earliest LATENCY+1 cycles after the request edge.
REQ-023 SHALL return responses in request order.
REQ-024 SHALL return table[req$v[DEPTH_LOG2-1:0]] when req$v[31:DEPTH_LOG2] is zero.
REQ-025 SHALL treat any nonzero upper bit as out of range: return MISS_VALUE (32'h00000001, a leaf with no route) and increment errCount, saturating at 16'hFFFF.
REQ-026 SHALL hold resValue stable while resValue__RDY is high and no resAccept occurs, and drive resValue as 0 when the queue is empty.
REQ-027 SHALL ignore resAccept__ENA while the queue is empty.
REQ-028 SHALL, when a table write and a read of the same address coincide, return the old data to the read (read-before-write) and make the new data visible to reads accepted from the next cycle.
REQ-029 SHALL support back-to-back requests at one per cycle while credits allow.

Reset
REQ-030 SHALL, while nRST is low, empty the pipeline valid bits and the queue and zero the credits and errCount, giving req__RDY=1, resValue__RDY=0, resAccept__RDY=0, resValue=0 and errCount=0.
REQ-031 SHALL drop any in-flight lookups when reset is asserted mid-operation; no stale response appears after reset is released.
REQ-032 SHALL NOT reset table contents, which are undefined until written.

Structure
REQ-033 SHALL take DEPTH_LOG2 default, MISS_VALUE and the ERRCNT width from shared package lpm_pkg.
REQ-034 SHALL implement the response queue as sub-module LpmResQueue (enq/first/deq, RESQ_DEPTH entries, wrap-around pointers plus count).

Verification
REQ-035 SHALL cover: write table[5]=32'h0000_0A10, then req 5 at cycle t -> resValue=32'h0000_0A10 with resValue__RDY=1 at cycle t+LATENCY+1.
REQ-036 SHALL cover: 6 back-to-back reqs with no resAccept, RESQ_DEPTH=4 -> exactly 4 accepted, req__RDY=0 afterwards; popping one restores req__RDY=1 the next cycle.
REQ-037 SHALL cover: req 32'h0001_0003 -> resValue=32'h1 and errCount=1; 70000 such reqs -> errCount=16'hFFFF.
REQ-038 SHALL cover: write table[7]=A and req 7 in one cycle, with old value B -> response B; req 7 the next cycle -> A.
REQ-039 SHALL cover: queue full with a simultaneous req and resAccept for 20 cycles -> credits stay 4, responses stay in order, no loss or duplication.
REQ-040 SHALL cover: nRST pulsed with 3 lookups in flight -> outputs at reset values and no response emitted in the 10 cycles after release.
